// File: rtl/pdm_pkg.sv
// Shared definitions for the multi-channel PDM delta-sigma modulator.
//   pdm_state_t : shared soft-mute FSM states
//   ORDER_1     : order_sel value selecting the first-order loop
//   ORDER_2     : order_sel value selecting the second-order loop
package pdm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } pdm_state_t;

    localparam logic ORDER_1 = 1'b0;
    localparam logic ORDER_2 = 1'b1;

endpackage

// File: rtl/pdm_dsm_ch.sv
// One delta-sigma modulator channel: gain scaling, one or two saturating
// integrators, 1-bit quantiser and a sticky overflow flag.
//   clk, rst_n : bit clock, asynchronous active-low reset
//   x          : held signed input sample
//   g          : soft-mute gain, 0 .. 2^RAMP_LOG2
//   idle       : FSM is in IDLE; integrators held at zero, output toggles
//   order      : latched loop order (ORDER_1 / ORDER_2)
//   ovf_clr    : synchronous clear of the overflow flag
//   pdm        : PDM output bit
//   ovf        : sticky integrator-saturation flag
module pdm_dsm_ch
    import pdm_pkg::*;
#(
    parameter int IN_WIDTH  = 37,
    parameter int GUARD     = 4,
    parameter int RAMP_LOG2 = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [IN_WIDTH-1:0] x,
    input  logic [RAMP_LOG2:0]         g,
    input  logic                       idle,
    input  logic                       order,
    input  logic                       ovf_clr,
    output logic                       pdm,
    output logic                       ovf
);

    localparam int ACC_WIDTH = IN_WIDTH + GUARD;
    // Product width: signed sample times unsigned gain (with its sign bit).
    localparam int PW = IN_WIDTH + RAMP_LOG2 + 2;
    // Two extra bits so a sum of three ACC_WIDTH terms cannot wrap before clamping.
    localparam int SW = ACC_WIDTH + 2;

    localparam logic signed [ACC_WIDTH-1:0] MAX_A  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_A  = -MAX_A;
    localparam logic signed [ACC_WIDTH-1:0] FB_POS = ACC_WIDTH'(1) <<< (IN_WIDTH - 1);
    localparam logic signed [ACC_WIDTH-1:0] FB_NEG = -FB_POS;

    logic signed [ACC_WIDTH-1:0] i1, i2, i1_n, i2_n, xs, fb;
    logic signed [PW-1:0]        prod, prod_sh;
    logic signed [SW-1:0]        s1, s2;
    logic                        sat1, sat2, sat;

    always_comb begin
        prod    = PW'(x) * PW'($signed({1'b0, g}));
        prod_sh = prod >>> RAMP_LOG2;
        xs      = ACC_WIDTH'(prod_sh);
        fb      = pdm ? FB_POS : FB_NEG;

        s1   = SW'(i1) + SW'(xs) - SW'(fb);
        sat1 = 1'b0;
        i1_n = ACC_WIDTH'(s1);
        if (s1 > SW'(MAX_A)) begin
            i1_n = MAX_A;
            sat1 = 1'b1;
        end else if (s1 < SW'(MIN_A)) begin
            i1_n = MIN_A;
            sat1 = 1'b1;
        end

        // Second stage integrates the already-clamped first stage.
        s2   = SW'(i2) + SW'(i1_n) - SW'(fb);
        sat2 = 1'b0;
        i2_n = ACC_WIDTH'(s2);
        if (s2 > SW'(MAX_A)) begin
            i2_n = MAX_A;
            sat2 = 1'b1;
        end else if (s2 < SW'(MIN_A)) begin
            i2_n = MIN_A;
            sat2 = 1'b1;
        end

        sat = sat1 | ((order == ORDER_2) & sat2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1  <= '0;
            i2  <= '0;
            pdm <= 1'b0;
            ovf <= 1'b0;
        end else if (idle) begin
            i1  <= '0;
            i2  <= '0;
            pdm <= ~pdm;
            if (ovf_clr) ovf <= 1'b0;
        end else begin
            i1 <= i1_n;
            if (order == ORDER_2) begin
                i2  <= i2_n;
                pdm <= ~i2_n[ACC_WIDTH-1];
            end else begin
                i2  <= '0;
                pdm <= ~i1_n[ACC_WIDTH-1];
            end
            // A saturation on this edge beats a simultaneous clear.
            if (sat)          ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/pdm_dsm_mc.sv
// Multi-channel PDM delta-sigma modulator with soft mute/unmute ramp.
//   clk, rst_n : bit clock, asynchronous active-low reset
//   in_data    : NUM_CH packed signed samples, channel 0 in the LSBs
//   in_valid   : one-cycle strobe for a new sample set (also steps the gain)
//   mute       : 1 fades to silence, 0 fades in
//   order_sel  : 0 first-order, 1 second-order (taken only while IDLE)
//   ovf_clr    : clears all overflow flags
//   pdm_out    : one PDM bit per channel
//   ovf        : sticky per-channel saturation flags
//   running    : high only in RUN
// Handshake: in_valid is a strobe with no back-pressure; every asserted
// cycle captures in_data and applies one gain step for the next state.
module pdm_dsm_mc
    import pdm_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int IN_WIDTH  = 37,
    parameter int GUARD     = 4,
    parameter int RAMP_LOG2 = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH*IN_WIDTH-1:0] in_data,
    input  logic                       in_valid,
    input  logic                       mute,
    input  logic                       order_sel,
    input  logic                       ovf_clr,
    output logic [NUM_CH-1:0]          pdm_out,
    output logic [NUM_CH-1:0]          ovf,
    output logic                       running
);

    localparam logic [RAMP_LOG2:0] G_FULL = {1'b1, {RAMP_LOG2{1'b0}}};
    localparam logic [RAMP_LOG2:0] G_ZERO = '0;
    localparam logic [RAMP_LOG2:0] G_ONE  = {{RAMP_LOG2{1'b0}}, 1'b1};

    pdm_state_t                 state, state_n;
    logic [RAMP_LOG2:0]         g;
    logic [NUM_CH*IN_WIDTH-1:0] hold;
    logic                       order_q;

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:      if (!mute) state_n = ST_RAMP_UP;
            ST_RAMP_UP:   if (mute) state_n = ST_RAMP_DOWN;
                          else if (g == G_FULL) state_n = ST_RUN;
            ST_RUN:       if (mute) state_n = ST_RAMP_DOWN;
            ST_RAMP_DOWN: if (!mute) state_n = ST_RAMP_UP;
                          else if (g == G_ZERO) state_n = ST_IDLE;
            default:      state_n = ST_IDLE;
        endcase
    end

    // The gain step is chosen by the state being entered, so a strobe that
    // coincides with a transition already ramps in the new direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            g       <= G_ZERO;
            hold    <= '0;
            order_q <= ORDER_2;
            running <= 1'b0;
        end else begin
            state   <= state_n;
            running <= (state_n == ST_RUN);
            if (state == ST_IDLE) order_q <= order_sel;
            if (in_valid) begin
                hold <= in_data;
                if (state_n == ST_RAMP_UP && g != G_FULL)
                    g <= g + G_ONE;
                else if (state_n == ST_RAMP_DOWN && g != G_ZERO)
                    g <= g - G_ONE;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pdm_dsm_ch #(
            .IN_WIDTH  (IN_WIDTH),
            .GUARD     (GUARD),
            .RAMP_LOG2 (RAMP_LOG2)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .x       (hold[c*IN_WIDTH +: IN_WIDTH]),
            .g       (g),
            .idle    (state == ST_IDLE),
            .order   (order_q),
            .ovf_clr (ovf_clr),
            .pdm     (pdm_out[c]),
            .ovf     (ovf[c])
        );
    end

endmodule

// File: tb/tb_pdm_dsm_mc.sv
// Bench for pdm_dsm_mc: directed scenarios plus randomized traffic, with a
// cycle-by-cycle arithmetic reference model of the modulator.
module tb_pdm_dsm_mc;

    localparam int NCH  = 2;
    localparam int W    = 37;
    localparam int GRD  = 4;
    localparam int R    = 8;
    localparam int ACC  = W + GRD;
    localparam longint H    = longint'(1) <<< (W - 1);
    localparam longint LIM  = (longint'(1) <<< (ACC - 1)) - 1;
    localparam longint GMAX = longint'(1) <<< R;

    localparam int M_SILENT = 0;
    localparam int M_UP     = 1;
    localparam int M_FULL   = 2;
    localparam int M_DOWN   = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH*W-1:0]     in_data;
    logic                 in_valid, mute, order_sel, ovf_clr;
    logic [NCH-1:0]       pdm_out, ovf;
    logic                 running;

    int checks   = 0;
    int failures = 0;
    int ones [NCH];
    bit collect  = 1'b0;
    bit hist0 [$];

    // reference model state
    int     m_mode;
    longint m_g;
    longint m_hold [NCH];
    longint m_i1 [NCH];
    longint m_i2 [NCH];
    bit     m_pdm [NCH];
    bit     m_ovf [NCH];
    bit     m_second;
    bit     m_run;

    pdm_dsm_mc #(.NUM_CH(NCH), .IN_WIDTH(W), .GUARD(GRD), .RAMP_LOG2(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .mute      (mute),
        .order_sel (order_sel),
        .ovf_clr   (ovf_clr),
        .pdm_out   (pdm_out),
        .ovf       (ovf),
        .running   (running)
    );

    always #5 clk = ~clk;

    function automatic longint clamp(input longint v, inout bit s);
        if (v > LIM) begin s = 1'b1; return LIM; end
        if (v < -LIM) begin s = 1'b1; return -LIM; end
        return v;
    endfunction

    task automatic model_reset();
        m_mode = M_SILENT; m_g = 0; m_second = 1'b1; m_run = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_hold[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_pdm[c] = 1'b0; m_ovf[c] = 1'b0;
        end
    endtask

    // One clock of the modulator, evaluated from the rules on plain integers.
    task automatic model_step();
        longint xs, f, a, b;
        bit s;
        int nm;
        for (int c = 0; c < NCH; c++) begin
            s = 1'b0;
            if (m_mode == M_SILENT) begin
                m_i1[c] = 0; m_i2[c] = 0; m_pdm[c] = !m_pdm[c];
            end else begin
                xs = (m_hold[c] * m_g) >>> R;
                f  = m_pdm[c] ? H : -H;
                a  = clamp(m_i1[c] + xs - f, s);
                if (m_second) begin
                    b = clamp(m_i2[c] + a - f, s);
                    m_i2[c] = b; m_pdm[c] = (b >= 0);
                end else begin
                    m_i2[c] = 0; m_pdm[c] = (a >= 0);
                end
                m_i1[c] = a;
            end
            if (s) m_ovf[c] = 1'b1;
            else if (ovf_clr) m_ovf[c] = 1'b0;
        end
        if (m_mode == M_SILENT) m_second = order_sel;
        nm = m_mode;
        case (m_mode)
            M_SILENT: if (!mute) nm = M_UP;
            M_UP:     nm = mute ? M_DOWN : (m_g == GMAX ? M_FULL : M_UP);
            M_FULL:   if (mute) nm = M_DOWN;
            default:  nm = !mute ? M_UP : (m_g == 0 ? M_SILENT : M_DOWN);
        endcase
        if (in_valid) begin
            if (nm == M_UP && m_g < GMAX) m_g++;
            else if (nm == M_DOWN && m_g > 0) m_g--;
            for (int c = 0; c < NCH; c++) m_hold[c] = longint'($signed(in_data[c*W +: W]));
        end
        m_mode = nm;
        m_run  = (nm == M_FULL);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic tick();
        logic [NCH-1:0] ep, eo;
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        #1;
        for (int c = 0; c < NCH; c++) begin
            ep[c] = m_pdm[c];
            eo[c] = m_ovf[c];
            ones[c] += int'(pdm_out[c]);
        end
        if (collect) hist0.push_back(pdm_out[0]);
        if (failures < 40) begin
            checks++;
            assert (pdm_out === ep) else begin
                failures++; $error("FAIL pdm_out observed=%b expected=%b t=%0t", pdm_out, ep, $time);
            end
            checks++;
            assert (ovf === eo) else begin
                failures++; $error("FAIL ovf observed=%b expected=%b t=%0t", ovf, eo, $time);
            end
            checks++;
            assert (running === m_run) else begin
                failures++; $error("FAIL running observed=%b expected=%b t=%0t", running, m_run, $time);
            end
        end
    endtask

    task automatic set_data(input longint v0, input longint v1);
        in_data[0 +: W] = v0[W-1:0];
        in_data[W +: W] = v1[W-1:0];
    endtask

    task automatic clear_ones();
        for (int c = 0; c < NCH; c++) ones[c] = 0;
    endtask

    task automatic pulse_train(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; tick(); in_valid = 1'b0;
            repeat (period - 1) tick();
        end
    endtask

    task automatic wait_running(input int period, output int cnt);
        cnt = 0;
        while (running !== 1'b1 && cnt < 300) begin
            in_valid = 1'b1; tick(); in_valid = 1'b0;
            repeat (period - 1) tick();
            cnt++;
        end
    endtask

    task automatic idle_toggle_check(input string tag);
        logic [NCH-1:0] prev;
        int bad;
        bad = 0; prev = pdm_out;
        repeat (8) begin
            tick();
            if (pdm_out !== ~prev) bad++;
            prev = pdm_out;
        end
        chk(tag, bad, 0);
    endtask

    function automatic longint rand_sample();
        case ($urandom_range(0, 3))
            0: return (longint'($urandom) <<< 5) - H;
            1: return longint'($urandom_range(0, 2000)) - 1000;
            2: return H - 1;
            default: return -H;
        endcase
    endfunction

    initial begin
        int cnt, bad, n;
        // ---------------- reset and idle toggling
        rst_n = 1'b0; in_valid = 1'b0; mute = 1'b1; order_sel = 1'b1; ovf_clr = 1'b0;
        in_data = '0;
        model_reset(); clear_ones();
        repeat (3) tick();
        chk("rst_pdm", pdm_out, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_running", running, 0);
        rst_n = 1'b1;
        chk("rel_pdm", pdm_out, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("idle_toggle_seq", pdm_out, (k % 2) ? 2'b11 : 2'b00);
            chk("idle_not_running", running, 0);
        end

        // ---------------- zero input fade-in, second order
        mute = 1'b0; set_data(0, 0);
        wait_running(64, cnt);
        chk("ramp_pulses_zero", cnt, 256);
        clear_ones();
        repeat (4096) tick();
        chk_range("zero_density_ch0", ones[0], 2046, 2050);
        chk_range("zero_density_ch1", ones[1], 2046, 2050);

        // ---------------- +/- half scale, second order
        set_data(longint'(1) <<< 35, -(longint'(1) <<< 35));
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        repeat (200) tick();
        clear_ones();
        repeat (8192) tick();
        chk_range("half_density_ch0", ones[0], 6103, 6185);
        chk_range("half_density_ch1", ones[1], 2007, 2089);
        chk("half_ovf", ovf, 0);

        // ---------------- order change ignored in RUN, fade out, first-order fade in
        order_sel = 1'b0;
        repeat (300) tick();
        chk("run_after_order_sel", running, 1);
        mute = 1'b1;
        pulse_train(256, 16);
        chk("faded_out_running", running, 0);
        idle_toggle_check("idle_after_fade");
        mute = 1'b0; set_data(longint'(1) <<< 34, 0);
        wait_running(16, cnt);
        chk("ramp_pulses_first", cnt, 256);
        repeat (16) tick();
        hist0.delete(); collect = 1'b1;
        repeat (64) tick();
        collect = 1'b0;
        bad = 0;
        for (int i = 0; i < 56; i++) if (hist0[i] != hist0[i+8]) bad++;
        chk("first_order_period8", bad, 0);
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(hist0[i]);
        chk("first_order_ones8", n, 5);

        // ---------------- saturation and overflow clear, second order
        order_sel = 1'b1; mute = 1'b1;
        pulse_train(256, 4);
        repeat (4) tick();
        mute = 1'b0; set_data((longint'(1) <<< 36) - 1, 0);
        wait_running(4, cnt);
        chk("ramp_pulses_sat", cnt, 256);
        n = 0;
        while (ovf[0] !== 1'b1 && n < 4000) begin tick(); n++; end
        chk("ovf0_set", ovf[0], 1);
        chk("ovf1_quiet", ovf[1], 0);
        repeat (50) tick();
        set_data(0, 0);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        repeat (400) tick();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 0);
        bad = 0;
        repeat (200) begin tick(); if (ovf !== 2'b00) bad++; end
        chk("ovf_stays_clear", bad, 0);

        // ---------------- randomized traffic with a mid-run reset
        for (int phase = 0; phase < 2; phase++) begin
            repeat (1500) begin
                in_valid = ($urandom_range(0, 2) == 0);
                if (in_valid) set_data(rand_sample(), rand_sample());
                if ($urandom_range(0, 149) == 0) mute = ~mute;
                if ($urandom_range(0, 299) == 0) order_sel = ~order_sel;
                ovf_clr = ($urandom_range(0, 49) == 0);
                tick();
            end
            in_valid = 1'b0; ovf_clr = 1'b0;
            if (phase == 0) begin
                #3 rst_n = 1'b0;
                #1;
                chk("async_rst_pdm", pdm_out, 0);
                chk("async_rst_ovf", ovf, 0);
                chk("async_rst_running", running, 0);
                model_reset();
                repeat (3) tick();
                rst_n = 1'b1;
                mute = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
